// File: rtl/fc_layer_scheduler.sv
// Group scheduler for the fully-connected MAC engine: fetches weight rows per
// group, steps the datapath across them and streams the results downstream.
module fc_layer_scheduler #(
    parameter int OUT_CHANNEL    = 64,
    parameter int WEIGHT_CHANNEL = 8,
    parameter int OUT_BANDWIDTH  = 24,
    parameter int ADDR_WIDTH     = 8,
    localparam int SW            = $clog2(WEIGHT_CHANNEL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     wmem_rd_en,
    output logic [ADDR_WIDTH-1:0]    wmem_rd_addr,
    input  logic                     wmem_rd_valid,
    output logic                     wload_en,
    output logic [SW-1:0]            wload_sel,
    output logic                     dp_nen,
    output logic [SW-1:0]            dp_sel,
    input  logic [OUT_BANDWIDTH-1:0] dp_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_BANDWIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]    out_idx
);

    localparam int NGROUP = OUT_CHANNEL / WEIGHT_CHANNEL;
    localparam int GW     = (NGROUP > 1) ? $clog2(NGROUP) : 1;
    localparam int CW     = SW + 1;

    localparam logic [CW-1:0] ZERO_CNT   = CW'(32'd0);
    localparam logic [CW-1:0] ONE_CNT    = CW'(32'd1);
    localparam logic [CW-1:0] WC_CNT     = CW'(WEIGHT_CHANNEL);
    localparam logic [CW-1:0] LAST_RET   = CW'(WEIGHT_CHANNEL - 1);
    localparam logic [SW-1:0] ZERO_SLOT  = SW'(32'd0);
    localparam logic [SW-1:0] ONE_SLOT   = SW'(32'd1);
    localparam logic [SW-1:0] LAST_SLOT  = SW'(WEIGHT_CHANNEL - 1);
    localparam logic [GW-1:0] ZERO_GRP   = GW'(32'd0);
    localparam logic [GW-1:0] ONE_GRP    = GW'(32'd1);
    localparam logic [GW-1:0] LAST_GROUP = GW'(NGROUP - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                   state_r;
    logic [GW-1:0]            group_r;
    logic [CW-1:0]            issue_cnt_r;
    logic [CW-1:0]            ret_cnt_r;
    logic [SW-1:0]            drain_cnt_r;
    logic [OUT_BANDWIDTH-1:0] res_r [WEIGHT_CHANNEL];

    // Output-channel index of a slot within a group (WEIGHT_CHANNEL is a power of two).
    function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [GW-1:0] grp,
                                                        input logic [SW-1:0] slot);
        row_addr = (ADDR_WIDTH'(grp) << SW) | ADDR_WIDTH'(slot);
    endfunction

    // Weight load strobe follows the memory return only while fetching.
    always_comb begin
        wload_en = 1'b0;
        if (state_r == ST_FETCH) begin
            wload_en = wmem_rd_valid;
        end else begin
            wload_en = 1'b0;
        end
    end

    assign wload_sel = ret_cnt_r[SW-1:0];

    // Layer sequencing FSM with all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            group_r      <= ZERO_GRP;
            issue_cnt_r  <= ZERO_CNT;
            ret_cnt_r    <= ZERO_CNT;
            drain_cnt_r  <= ZERO_SLOT;
            busy         <= 1'b0;
            done         <= 1'b0;
            wmem_rd_en   <= 1'b0;
            wmem_rd_addr <= {ADDR_WIDTH{1'b0}};
            dp_nen       <= 1'b1;
            dp_sel       <= ZERO_SLOT;
            out_valid    <= 1'b0;
            out_data     <= {OUT_BANDWIDTH{1'b0}};
            out_idx      <= {ADDR_WIDTH{1'b0}};
            for (int i = 0; i < WEIGHT_CHANNEL; i++) begin
                res_r[i] <= {OUT_BANDWIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r      <= ST_FETCH;
                        busy         <= 1'b1;
                        group_r      <= ZERO_GRP;
                        issue_cnt_r  <= ONE_CNT;
                        ret_cnt_r    <= ZERO_CNT;
                        wmem_rd_en   <= 1'b1;
                        wmem_rd_addr <= row_addr(ZERO_GRP, ZERO_SLOT);
                    end
                end

                ST_FETCH: begin
                    // issue_cnt counts reads already presented on the port
                    if (issue_cnt_r < WC_CNT) begin
                        wmem_rd_en   <= 1'b1;
                        wmem_rd_addr <= row_addr(group_r, issue_cnt_r[SW-1:0]);
                        issue_cnt_r  <= issue_cnt_r + ONE_CNT;
                    end else begin
                        wmem_rd_en <= 1'b0;
                    end
                    if (wmem_rd_valid && (ret_cnt_r < WC_CNT)) begin
                        ret_cnt_r <= ret_cnt_r + ONE_CNT;
                        if (ret_cnt_r == LAST_RET) begin
                            state_r    <= ST_COMPUTE;
                            wmem_rd_en <= 1'b0;
                            dp_nen     <= 1'b0;
                            dp_sel     <= ZERO_SLOT;
                        end
                    end
                end

                ST_COMPUTE: begin
                    res_r[dp_sel] <= dp_result;
                    if (dp_sel == LAST_SLOT) begin
                        state_r     <= ST_DRAIN;
                        dp_nen      <= 1'b1;
                        dp_sel      <= ZERO_SLOT;
                        drain_cnt_r <= ZERO_SLOT;
                        out_valid   <= 1'b1;
                        // slot 0 is only still in flight when the bank holds a single row
                        out_data    <= (dp_sel == ZERO_SLOT) ? dp_result : res_r[0];
                        out_idx     <= row_addr(group_r, ZERO_SLOT);
                    end else begin
                        dp_sel <= dp_sel + ONE_SLOT;
                    end
                end

                ST_DRAIN: begin
                    if (out_ready) begin
                        if (drain_cnt_r == LAST_SLOT) begin
                            out_valid <= 1'b0;
                            if (group_r == LAST_GROUP) begin
                                state_r <= ST_DONE;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                            end else begin
                                state_r      <= ST_FETCH;
                                group_r      <= group_r + ONE_GRP;
                                issue_cnt_r  <= ONE_CNT;
                                ret_cnt_r    <= ZERO_CNT;
                                wmem_rd_en   <= 1'b1;
                                wmem_rd_addr <= row_addr(group_r + ONE_GRP, ZERO_SLOT);
                            end
                        end else begin
                            drain_cnt_r <= drain_cnt_r + ONE_SLOT;
                            out_data    <= res_r[drain_cnt_r + ONE_SLOT];
                            out_idx     <= row_addr(group_r, drain_cnt_r + ONE_SLOT);
                        end
                    end
                end

                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    state_r    <= ST_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    wmem_rd_en <= 1'b0;
                    dp_nen     <= 1'b1;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Directed bench for fc_layer_scheduler: memory model with latency/gaps,
// datapath model, output scoreboard and reset/start-while-busy cases.
module tb_fc_layer_scheduler;

    localparam int OC = 64;
    localparam int WC = 8;
    localparam int OB = 24;
    localparam int AW = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, wmem_rd_en, wload_en, dp_nen, out_valid;
    logic          wmem_rd_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] wmem_rd_addr, out_idx;
    logic [SW-1:0] wload_sel, dp_sel;
    logic [OB-1:0] dp_result, out_data;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int cur_lat = 1, cur_gap = 0, cur_rdy = 0;
    bit cur_spur = 1'b0;
    int mq[$];

    int exp_addr, exp_idx, exp_sel, nen_cnt, done_cnt, comp_groups;
    bit prev_nen, prev_stall;
    logic [OB-1:0] prev_data;
    logic [AW-1:0] prev_idx;

    fc_layer_scheduler #(
        .OUT_CHANNEL(OC), .WEIGHT_CHANNEL(WC), .OUT_BANDWIDTH(OB), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .wmem_rd_en(wmem_rd_en), .wmem_rd_addr(wmem_rd_addr), .wmem_rd_valid(wmem_rd_valid),
        .wload_en(wload_en), .wload_sel(wload_sel), .dp_nen(dp_nen), .dp_sel(dp_sel),
        .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: result depends on the row and the group being computed.
    assign dp_result = OB'(32'd1000 + 32'(dp_sel) + 32'(comp_groups) * 32'd8);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rd_en", 32'(wmem_rd_en), 32'd0);
        check_eq("rst_rd_addr", 32'(wmem_rd_addr), 32'd0);
        check_eq("rst_wload_en", 32'(wload_en), 32'd0);
        check_eq("rst_wload_sel", 32'(wload_sel), 32'd0);
        check_eq("rst_dp_nen", 32'(dp_nen), 32'd1);
        check_eq("rst_dp_sel", 32'(dp_sel), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_idx", 32'(out_idx), 32'd0);
    endtask

    // One cycle of stimulus: memory request capture, returns, backpressure.
    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        if (wmem_rd_en) mq.push_back(cyc + cur_lat);
        wmem_rd_valid = 1'b0;
        if (mq.size() > 0 && mq[0] <= cyc && int'($urandom_range(0, 99)) >= cur_gap) begin
            wmem_rd_valid = 1'b1;
            void'(mq.pop_front());
        end else if (cur_spur && mq.size() == 0 && (out_valid || !busy) && $urandom_range(0, 1) == 1) begin
            wmem_rd_valid = 1'b1;
        end
        out_ready = (int'($urandom_range(0, 99)) >= cur_rdy);
    endtask

    task automatic monitor_loop();
        bit fetch_ph;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_nen   = 1'b1;
                prev_stall = 1'b0;
            end else begin
                fetch_ph = busy && dp_nen && !out_valid;
                check_eq("wload_en", 32'(wload_en), 32'(wmem_rd_valid && fetch_ph));
                if (wload_en) begin
                    check_eq("wload_sel", 32'(wload_sel), 32'(exp_sel % WC));
                    exp_sel++;
                end
                if (!busy) check_eq("rd_en_idle", 32'(wmem_rd_en), 32'd0);
                if (wmem_rd_en) begin
                    check_eq("rd_addr", 32'(wmem_rd_addr), 32'(exp_addr));
                    if (exp_addr % WC == 0) check_eq("fetch_after_drain", 32'(exp_idx), 32'(exp_addr));
                    exp_addr++;
                end
                if (!dp_nen) begin
                    if (prev_nen) begin
                        check_eq("compute_after_returns", 32'(exp_sel), 32'(WC));
                        exp_sel = 0;
                    end
                    check_eq("dp_sel", 32'(dp_sel), 32'(nen_cnt));
                    nen_cnt++;
                end else if (!prev_nen) begin
                    check_eq("compute_len", 32'(nen_cnt), 32'(WC));
                    nen_cnt = 0;
                    comp_groups++;
                end
                prev_nen = dp_nen;
                if (prev_stall) begin
                    check_eq("hold_valid", 32'(out_valid), 32'd1);
                    check_eq("hold_data", 32'(out_data), 32'(prev_data));
                    check_eq("hold_idx", 32'(out_idx), 32'(prev_idx));
                end
                if (out_valid && out_ready) begin
                    check_eq("beat_idx", 32'(out_idx), 32'(exp_idx));
                    check_eq("beat_data", 32'(out_data), 32'(1000 + exp_idx));
                    exp_idx++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_idx   = out_idx;
                if (done) done_cnt++;
            end
        end
    endtask

    task automatic run_layer(input int lat, input int gap, input int rdy, input bit spur,
                             input bit pulse, input int rst_grp, input int exp_cyc);
        int s_cyc;
        bit fs, ds, got;
        fs = 1'b0; ds = 1'b0; got = 1'b0;
        cur_lat = lat; cur_gap = gap; cur_rdy = rdy; cur_spur = spur;
        exp_addr = 0; exp_idx = 0; exp_sel = 0; nen_cnt = 0; done_cnt = 0; comp_groups = 0;
        prev_nen = 1'b1; prev_stall = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("rd_en_after_start", 32'(wmem_rd_en), 32'd1);
        s_cyc = cyc;
        for (int i = 0; i < 6000 && !got; i++) begin
            tick();
            if (pulse && !fs && wmem_rd_en && i > 20) begin
                start = 1'b1;
                fs = 1'b1;
            end else if (pulse && !ds && out_valid && i > 40) begin
                start = 1'b1;
                ds = 1'b1;
            end
            if (rst_grp >= 0 && comp_groups == rst_grp && !dp_nen) begin
                @(negedge clk);
                #2;
                rst = 1'b1;
                #1;
                check_reset_outputs();
                repeat (3) tick();
                rst = 1'b0;
                return;
            end
            if (done) begin
                got = 1'b1;
                if (exp_cyc > 0) check_eq("layer_cycles", 32'(cyc - s_cyc), 32'(exp_cyc));
                check_eq("busy_at_done", 32'(busy), 32'd0);
            end
        end
        if (!got) check_eq("done_timeout", 32'd0, 32'd1);
        repeat (3) tick();
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("addr_count", 32'(exp_addr), 32'(OC));
        check_eq("beat_count", 32'(exp_idx), 32'(OC));
        check_eq("group_count", 32'(comp_groups), 32'(OC / WC));
        check_eq("busy_after_layer", 32'(busy), 32'd0);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        tick();
        check_reset_outputs();

        run_layer(1, 0, 0, 1'b0, 1'b0, -1, 200);
        run_layer(5, 50, 0, 1'b0, 1'b0, -1, 0);
        run_layer(2, 20, 30, 1'b0, 1'b0, -1, 0);
        run_layer(3, 0, 0, 1'b0, 1'b1, -1, 0);
        run_layer(2, 0, 10, 1'b1, 1'b0, -1, 0);
        run_layer(4, 30, 20, 1'b0, 1'b0, 3, 0);
        for (int i = 0; i < 300 && mq.size() > 0; i++) tick();
        repeat (4) tick();
        run_layer(1, 0, 0, 1'b0, 1'b0, -1, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
